// File: rtl/ucode_loader_if.sv
// rtl/ucode_loader_if.sv - byte stream, control-store read port and loader status bundle
interface ucode_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              run;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output rx_valid, rx_data, rd_addr,
    input  rd_data, run, busy, err, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, rd_addr,
    output rd_data, run, busy, err, words_loaded
  );
endinterface

// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - writable control store filled from a framed, checksummed byte stream
module ucode_loader #(
  parameter int          ADDR_W  = 4,
  parameter int          DATA_W  = 24,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input logic          clock,
  input logic          reset,
  ucode_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   ONE_W = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, RUN, ERROR} state_t;

  state_t            state, state_d;
  logic              run, run_d, busy, busy_d, err, err_d;
  logic [ADDR_W:0]   words_loaded, wl_d, n_words, n_d;
  logic [7:0]        sum, sum_d, b0, b0_d, b1, b1_d, sum_chk;
  logic [15:0]       timer, timer_d;
  logic [ADDR_W-1:0] waddr, waddr_d;
  logic [1:0]        bytesel, bytesel_d;
  logic              we, in_frame, is_sync;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  assign in_frame = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign is_sync  = bus.rx_valid && (bus.rx_data == SYNC);
  assign sum_chk  = sum + bus.rx_data;

  always_comb begin
    state_d   = state;
    run_d     = run;
    busy_d    = busy;
    err_d     = err;
    wl_d      = words_loaded;
    sum_d     = sum;
    waddr_d   = waddr;
    bytesel_d = bytesel;
    b0_d      = b0;
    b1_d      = b1;
    n_d       = n_words;
    we        = 1'b0;
    wdata     = {bus.rx_data, b1, b0};
    timer_d   = (in_frame && !bus.rx_valid) ? timer + 16'd1 : 16'd0;

    case (state)
      IDLE, RUN, ERROR: begin
        if (is_sync) begin
          state_d   = COUNT;
          run_d     = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          wl_d      = '0;
          sum_d     = 8'h00;
          waddr_d   = '0;
          bytesel_d = 2'd0;
        end
      end
      COUNT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h00 || int'(bus.rx_data) > DEPTH) begin
            state_d = ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            n_d     = (ADDR_W+1)'(bus.rx_data);
            sum_d   = bus.rx_data;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          sum_d = sum_chk;
          case (bytesel)
            2'd0: begin b0_d = bus.rx_data; bytesel_d = 2'd1; end
            2'd1: begin b1_d = bus.rx_data; bytesel_d = 2'd2; end
            default: begin
              we        = 1'b1;
              waddr_d   = waddr + ONE_A;
              wl_d      = words_loaded + ONE_W;
              bytesel_d = 2'd0;
              if (wl_d == n_words) state_d = CHECK;
            end
          endcase
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          busy_d = 1'b0;
          if (sum_chk == 8'h00) begin
            state_d = RUN;
            run_d   = 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An arriving byte on the expiry cycle takes precedence over the timeout.
    if (in_frame && !bus.rx_valid && timer == TIMEOUT - 16'd1) begin
      state_d = ERROR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      run          <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      sum          <= 8'h00;
      timer        <= 16'd0;
      waddr        <= '0;
      bytesel      <= 2'd0;
      b0           <= 8'h00;
      b1           <= 8'h00;
      n_words      <= '0;
    end else begin
      state        <= state_d;
      run          <= run_d;
      busy         <= busy_d;
      err          <= err_d;
      words_loaded <= wl_d;
      sum          <= sum_d;
      timer        <= timer_d;
      waddr        <= waddr_d;
      bytesel      <= bytesel_d;
      b0           <= b0_d;
      b1           <= b1_d;
      n_words      <= n_d;
    end
  end

  // RAM is deliberately outside reset so a reset mid-frame keeps partial writes.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  assign bus.rd_data      = mem[bus.rd_addr];
  assign bus.run          = run;
  assign bus.busy         = busy;
  assign bus.err          = err;
  assign bus.words_loaded = words_loaded;
endmodule

// File: tb/tb_ucode_loader.sv
// tb/tb_ucode_loader.sv - directed vector bench for the microcode loader
module tb_ucode_loader;
  localparam int          ADDR_W  = 4;
  localparam int          DATA_W  = 24;
  localparam logic [15:0] TIMEOUT = 16'd4000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ucode_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ucode_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]  data;
    logic        run;
    logic        busy;
    logic        err;
    logic [4:0]  wl;
    logic        chk_rd;
    logic [23:0] rd;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic check_status(input string tag, input logic r, input logic b, input logic e, input logic [4:0] w);
    check({tag, ".run"},  {31'd0, bus.run},  {31'd0, r});
    check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
    check({tag, ".err"},  {31'd0, bus.err},  {31'd0, e});
    check({tag, ".wl"},   {27'd0, bus.words_loaded}, {27'd0, w});
  endtask

  initial begin
    logic [7:0]  chk;
    logic [23:0] word;

    // data, run, busy, err, words_loaded, check rd_data@0, expected rd_data
    vecs.push_back('{8'hA5, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h01, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h11, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h22, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h33, 0, 1, 0, 5'd1, 1, 24'h332211});
    vecs.push_back('{8'h99, 1, 0, 0, 5'd1, 1, 24'h332211});
    vecs.push_back('{8'hA5, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h01, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h11, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h22, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h33, 0, 1, 0, 5'd1, 0, 24'h0});
    vecs.push_back('{8'h99, 1, 0, 0, 5'd1, 0, 24'h0});
    vecs.push_back('{8'hA5, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h01, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h11, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h22, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h33, 0, 1, 0, 5'd1, 0, 24'h0});
    vecs.push_back('{8'h98, 0, 0, 1, 5'd1, 1, 24'h332211});
    vecs.push_back('{8'h55, 0, 0, 1, 5'd1, 0, 24'h0});
    vecs.push_back('{8'hA5, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h00, 0, 0, 1, 5'd0, 0, 24'h0});
    vecs.push_back('{8'hA5, 0, 1, 0, 5'd0, 0, 24'h0});
    vecs.push_back('{8'h11, 0, 0, 1, 5'd0, 0, 24'h0});

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_addr  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_status("reset", 0, 0, 0, 5'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].data);
      check_status($sformatf("vec%0d", i), vecs[i].run, vecs[i].busy, vecs[i].err, vecs[i].wl);
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d.rd", i), {8'd0, bus.rd_data}, {8'd0, vecs[i].rd});
    end

    // Full-depth frame: word k = {k0, k1, k2}
    send_byte(8'hA5);
    send_byte(8'd16);
    chk = 8'd16;
    for (int k = 0; k < 16; k++) begin
      word = {8'(k * 16), 8'(k * 16 + 1), 8'(k * 16 + 2)};
      for (int j = 0; j < 3; j++) begin
        send_byte(word[j*8 +: 8]);
        chk = chk + word[j*8 +: 8];
      end
    end
    send_byte(8'h00 - chk);
    check_status("full", 1, 0, 0, 5'd16);
    for (int k = 0; k < 16; k++) begin
      bus.rd_addr = 4'(k);
      #1;
      check($sformatf("full.rd%0d", k), {8'd0, bus.rd_data},
            {8'd0, 8'(k * 16), 8'(k * 16 + 1), 8'(k * 16 + 2)});
    end
    bus.rd_addr = '0;
    @(negedge clock);

    // Timeout fires exactly TIMEOUT cycles after the last byte
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    repeat (TIMEOUT - 1) @(negedge clock);
    check_status("to.before", 0, 1, 0, 5'd0);
    @(negedge clock);
    check_status("to.expire", 0, 0, 1, 5'd0);

    // A byte on the expiry cycle keeps the frame alive
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    repeat (TIMEOUT - 1) @(negedge clock);
    send_byte(8'h22);
    check_status("to.rescue", 0, 1, 0, 5'd0);
    send_byte(8'h33);
    send_byte(8'h99);
    check_status("to.done", 1, 0, 0, 5'd1);

    // Reset mid-DATA, then a clean reload
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_status("rst.mid", 0, 0, 0, 5'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h00);
    check_status("rst.reload", 1, 0, 0, 5'd1);
    check("rst.rd0", {8'd0, bus.rd_data}, {8'd0, 24'h665544});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
